id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select logic that sits directly upstream of the ALU.
- Captures decoded fields each cycle and drives the ALU's two operands and 4-bit op code.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, stalls decode and inserts a bubble.

Parameters:
- DATA_WIDTH, 32, width of operands, PC, immediate and forwarded results.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- Flush  in  1  branch/jump redirect; kill the instruction entering E
- HoldE  in  1  downstream wait; freeze the E register
- ValidD  in  1  decode slot holds a real instruction
- RD1D, RD2D  in  DATA_WIDTH  register-file read data
- ImmExtD  in  DATA_WIDTH  sign-extended immediate
- PCD  in  DATA_WIDTH  instruction PC
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  source and destination indices
- ALUctrlD  in  4  ALU op code
- ALUSrcAD  in  1  1 = operand A is PC
- ALUSrcBD  in  1  1 = operand B is the immediate
- RegWriteD, MemReadD, MemWriteD  in  1  control bits
- RdM  in  REG_ADDR_WIDTH  MEM-stage destination
- RegWriteM  in  1  MEM-stage write enable
- ALUResultM  in  DATA_WIDTH  MEM-stage ALU result
- RdW  in  REG_ADDR_WIDTH  WB-stage destination
- RegWriteW  in  1  WB-stage write enable
- ResultW  in  DATA_WIDTH  WB-stage result
- ALUop1, ALUop2  out  DATA_WIDTH  ALU operands (combinational from E register and forwards)
- ALUctrl  out  4  registered op code
- WriteDataE  out  DATA_WIDTH  forwarded rs2, used as store data
- PCE  out  DATA_WIDTH  registered PC
- RdE  out  REG_ADDR_WIDTH  registered destination
- RegWriteE, MemReadE, MemWriteE, ValidE  out  1  registered control bits
- StallD  out  1  hold PC and the IF/ID register

Behaviour:
- Reset: asynchronous and active-high. All E-register fields clear to 0, so the stage holds a bubble. Resulting outputs: ValidE, RegWriteE, MemReadE and MemWriteE are 0; ALUctrl = 4'b0000; RdE = 0; PCE = 0. ALUop1, ALUop2 and WriteDataE are 0 (no forward can match Rd=0). StallD = 0.
- Reset asserted mid-stall or mid-hold discards the held instruction.
- Hazard: hazard = MemReadE & ValidE & (RdE!=0) & ValidD & ((RdE==Rs1D) | (RdE==Rs2D)). Combinational.
- StallD = (hazard | HoldE) & ~Flush.
- E-register update on posedge clk, priority highest first:
  1. Flush: load a bubble (all control bits 0, RdE=0, ALUctrl=0).
  2. HoldE: keep all fields.
  3. hazard: load a bubble.
  4. Otherwise: load all D-stage fields.
  5. ValidD=0 also loads a bubble.
- Latency: a D-stage instruction appears on the outputs 1 cycle later. A load-use hazard adds exactly 1 bubble cycle.
- Forward select for operand A (Rs1E); operand B (Rs2E) uses the same rule:
  - If RegWriteM & (RdM!=0) & (RdM==Rs1E): select ALUResultM.
  - Else if RegWriteW & (RdW!=0) & (RdW==Rs1E): select ResultW.
  - Else: select the registered RD1E.
  - MEM wins over WB when both match. x0 is never forwarded.
- ALUop1 = ALUSrcAE ? PCE : fwdA.
- ALUop2 = ALUSrcBE ? ImmE : fwdB.
- WriteDataE = fwdB always, regardless of ALUSrcBE.
- Forwarding is purely combinational. No extra cycle is added.
- Simultaneous Flush and hazard: Flush wins, StallD=0, a bubble is inserted.
- Simultaneous HoldE and hazard: the register is held and StallD=1. The hazard is re-evaluated once the hold lifts.
- Bubble invariant: any bubble must have RegWriteE=MemReadE=MemWriteE=ValidE=0.

Decomposition:
- Shared package (cpu_pkg):
  - ALU op constants: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001, PASSB=1010.
  - fwd_sel_t enum: FWD_REG, FWD_MEM, FWD_WB.
  - idex_t packed struct: the E-register payload.
  - BUBBLE constant of type idex_t.
- One sub-module, forward_unit: computes the fwd_sel_t for one source index and is instantiated twice (A and B).

Test Plan:
- Reset: assert rst mid-stream with RegWriteD=1 → ValidE=0, RegWriteE=0, ALUop1=0, ALUop2=0 immediately; release and issue ADD with RD1D=5, RD2D=7 → next cycle ALUop1=5, ALUop2=7, ALUctrl=0000.
- MEM/WB forwarding, both match: Rs1E=3, RdM=3, RegWriteM=1, ALUResultM=0x10; RdW=3, RegWriteW=1, ResultW=0x20 → ALUop1=0x10. Drop RegWriteM → ALUop1=0x20.
- x0 is not forwarded: RdM=0, RegWriteM=1, ALUResultM=0xFF, Rs1E=0, RD1E=0 → ALUop1=0.
- Load-use hazard: load with RdE=4 in E, ADD with Rs2D=4 in D → StallD=1 for 1 cycle; the next E is a bubble (ValidE=0); the following cycle the ADD enters E and picks up the load result via the WB/MEM forward.
- Flush priority: Flush=1 together with hazard=1 and HoldE=0 → StallD=0; next cycle RegWriteE=0, MemWriteE=0, ValidE=0.
- Operand select and hold: ALUSrcAD=1, PCD=0x100, ALUSrcBD=1, ImmExtD=0x8, RD2D=0x55 → ALUop1=0x100, ALUop2=0x8, WriteDataE=0x55; assert HoldE for 3 cycles → all outputs stable and StallD=1 throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, forward-select encoding and the ID/EX payload.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src_a;
    logic            alu_src_b;
    logic [3:0]      alu_ctrl;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
  } idex_t;

  // All-zero payload: no side effects, and Rs=0 so no forward can ever match.
  localparam idex_t BUBBLE = '0;

endpackage

// File: rtl/forward_unit.sv
// Picks the freshest source for one E-stage register index; MEM beats WB, x0 never forwards.
module forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = RAW
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic                      reg_write_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_w,
  output fwd_sel_t                  sel
);

  always_comb begin
    sel = FWD_REG;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with load-use stall, bubble insertion and MEM/WB operand forwarding.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,
  parameter int REG_ADDR_WIDTH = RAW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Flush,
  input  logic                      HoldE,
  input  logic                      ValidD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [3:0]                ALUctrlD,
  input  logic                      ALUSrcAD,
  input  logic                      ALUSrcBD,
  input  logic                      RegWriteD,
  input  logic                      MemReadD,
  input  logic                      MemWriteD,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic [DATA_WIDTH-1:0]     ALUop1,
  output logic [DATA_WIDTH-1:0]     ALUop2,
  output logic [3:0]                ALUctrl,
  output logic [DATA_WIDTH-1:0]     WriteDataE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      RegWriteE,
  output logic                      MemReadE,
  output logic                      MemWriteE,
  output logic                      ValidE,
  output logic                      StallD
);

  idex_t    idex_q, idex_d;
  logic     hazard;
  fwd_sel_t sel_a, sel_b;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

  function automatic logic [DATA_WIDTH-1:0] fwd_mux(input fwd_sel_t sel,
                                                    input logic [DATA_WIDTH-1:0] reg_val,
                                                    input logic [DATA_WIDTH-1:0] mem_val,
                                                    input logic [DATA_WIDTH-1:0] wb_val);
    case (sel)
      FWD_MEM: fwd_mux = mem_val;
      FWD_WB:  fwd_mux = wb_val;
      default: fwd_mux = reg_val;
    endcase
  endfunction

  // Load in E whose destination is read by the instruction in D: its data is not ready yet.
  always_comb begin
    hazard = idex_q.mem_read && idex_q.valid && (idex_q.rd != '0) && ValidD &&
             ((idex_q.rd == Rs1D) || (idex_q.rd == Rs2D));
    StallD = (hazard || HoldE) && !Flush;
  end

  always_comb begin
    idex_d = idex_q;
    if (Flush) begin
      idex_d = BUBBLE;
    end else if (HoldE) begin
      idex_d = idex_q;
    end else if (hazard || !ValidD) begin
      idex_d = BUBBLE;
    end else begin
      idex_d.valid     = 1'b1;
      idex_d.reg_write = RegWriteD;
      idex_d.mem_read  = MemReadD;
      idex_d.mem_write = MemWriteD;
      idex_d.alu_src_a = ALUSrcAD;
      idex_d.alu_src_b = ALUSrcBD;
      idex_d.alu_ctrl  = ALUctrlD;
      idex_d.rs1       = Rs1D;
      idex_d.rs2       = Rs2D;
      idex_d.rd        = RdD;
      idex_d.pc        = PCD;
      idex_d.imm       = ImmExtD;
      idex_d.rd1       = RD1D;
      idex_d.rd2       = RD2D;
    end
  end

  // ---- D -> E register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs          (idex_q.rs1),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (sel_a)
  );

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs          (idex_q.rs2),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (sel_b)
  );

  // ---- E stage: operand select feeding the ALU ----
  always_comb begin
    fwd_a      = fwd_mux(sel_a, idex_q.rd1, ALUResultM, ResultW);
    fwd_b      = fwd_mux(sel_b, idex_q.rd2, ALUResultM, ResultW);
    ALUop1     = idex_q.alu_src_a ? idex_q.pc  : fwd_a;
    ALUop2     = idex_q.alu_src_b ? idex_q.imm : fwd_b;
    WriteDataE = fwd_b;
    ALUctrl    = idex_q.alu_ctrl;
    PCE        = idex_q.pc;
    RdE        = idex_q.rd;
    RegWriteE  = idex_q.reg_write;
    MemReadE   = idex_q.mem_read;
    MemWriteE  = idex_q.mem_write;
    ValidE     = idex_q.valid;
  end

endmodule
